// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores: LSU has fixed priority,
// IFU is forced through after STARVE_LIMIT losses, and a stuck memory yields an error response.
module ysyx_23060187_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int MASK_W = DATA_W / 8;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam int TW     = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                owner_q, owner_d;
  logic                grant_ifu, grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      timer_q  <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    owner_d   = owner_q;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are gated by rst so the readies read 0 while reset is held.
        if (!rst) begin
          if (lsu_req_valid && !(ifu_req_valid && starve_q == STARVE_MAX)) begin
            grant_lsu = 1'b1;
          end else if (ifu_req_valid) begin
            grant_ifu = 1'b1;
          end
        end
        if (grant_lsu) begin
          addr_d   = lsu_addr;
          wen_d    = lsu_wen;
          wdata_d  = lsu_wdata;
          wmask_d  = lsu_wmask;
          owner_d  = 1'b1;
          state_d  = REQ;
          starve_d = !ifu_req_valid ? '0 :
                     (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
        end else if (grant_ifu) begin
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          owner_d  = 1'b0;
          state_d  = REQ;
          starve_d = '0;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        // A response landing on the final timer cycle still counts as a success.
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TIMER_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign mem_req_valid  = (state_q == REQ);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = (state_q == RESP) && !owner_q;
  assign lsu_resp_valid = (state_q == RESP) && owner_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign busy           = (state_q != IDLE);
  assign owner          = owner_q;

endmodule
